// File: rtl/apb_node_pkg.sv
// apb_node_pkg: shared FSM state type and default access timeout for the APB node
package apb_node_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int TIMEOUT_CYCLES_DEF = 256;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: inclusive range decode, lowest matching slave index wins
module apb_addr_decode #(
  parameter int NB_MASTER      = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int IDX_WIDTH      = 3
) (
  input  logic [APB_ADDR_WIDTH-1:0]           addr,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] start_addr,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] end_addr,
  output logic                                hit,
  output logic [IDX_WIDTH-1:0]                idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    // walk downwards so the lowest overlapping index is the last to assign
    for (int i = NB_MASTER - 1; i >= 0; i--)
      if (addr >= start_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
          addr <= end_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = IDX_WIDTH'(i);
      end
  end
endmodule

// File: rtl/apb_node_reg.sv
// apb_node_reg: registered 1-to-NB_MASTER APB bridge; APB_NODE_TIMEOUT_EN adds an ACCESS-phase timeout
module apb_node_reg
  import apb_node_pkg::*;
#(
  parameter int NB_MASTER      = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                psel_i,
  input  logic                                penable_i,
  input  logic                                pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]           prdata_o,
  output logic                                pready_o,
  output logic                                pslverr_o,
  output logic [NB_MASTER-1:0]                psel_o,
  output logic [NB_MASTER-1:0]                penable_o,
  output logic [NB_MASTER-1:0]                pwrite_o,
  output logic [NB_MASTER*APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [NB_MASTER*APB_DATA_WIDTH-1:0] pwdata_o,
  input  logic [NB_MASTER*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NB_MASTER-1:0]                pready_i,
  input  logic [NB_MASTER-1:0]                pslverr_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0] END_ADDR_i
);
  localparam int IW = NB_MASTER > 1 ? $clog2(NB_MASTER) : 1;
  state_t                    state, state_d;
  logic                      dec_hit, start, pready_sel, timeout;
  logic [IW-1:0]             dec_idx, idx_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                      write_q, err_q, abort_q;

  apb_addr_decode #(
    .NB_MASTER(NB_MASTER), .APB_ADDR_WIDTH(APB_ADDR_WIDTH), .IDX_WIDTH(IW)
  ) u_dec (
    .addr(paddr_i), .start_addr(START_ADDR_i), .end_addr(END_ADDR_i),
    .hit(dec_hit), .idx(dec_idx)
  );

  assign start      = state == IDLE && psel_i && !penable_i;
  assign pready_sel = pready_i[idx_q];

`ifdef APB_NODE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= state != ACCESS ? '0 : pready_sel ? cnt : cnt + 1'b1;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = dec_hit ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_sel || timeout) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state <= state_d;
      if (start) begin
        addr_q  <= paddr_i;
        wdata_q <= pwdata_i;
        write_q <= pwrite_i;
        idx_q   <= dec_idx;
        err_q   <= !dec_hit;
        rdata_q <= '0;
        abort_q <= 1'b0;
      end
      // the slave response takes priority over a timeout in the same cycle
      if (state == ACCESS && pready_sel) begin
        rdata_q <= write_q ? '0 : prdata_i[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        err_q   <= pslverr_i[idx_q];
      end else if (state == ACCESS && timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if ((state == SETUP || state == ACCESS) && !psel_i) abort_q <= 1'b1;
    end

  always_comb begin
    psel_o    = '0;
    penable_o = '0;
    pwrite_o  = '0;
    paddr_o   = '0;
    pwdata_o  = '0;
    if (state == SETUP || state == ACCESS) begin
      psel_o[idx_q]                                       = 1'b1;
      penable_o[idx_q]                                    = state == ACCESS;
      pwrite_o[idx_q]                                     = write_q;
      paddr_o[idx_q*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]     = addr_q;
      pwdata_o[idx_q*APB_DATA_WIDTH +: APB_DATA_WIDTH]    = wdata_q;
    end
  end

  assign pready_o  = state == RESP && !abort_q;
  assign pslverr_o = pready_o && err_q;
  assign prdata_o  = pready_o ? rdata_q : '0;
endmodule

// File: tb/tb_apb_node_reg.sv
// tb_apb_node_reg: directed APB transfers with a response scoreboard and two behavioural slaves
module tb_apb_node_reg;
  logic        clk = 1'b0, rst = 1'b1;
  logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0] paddr_i = '0, pwdata_i = '0, prdata_o;
  logic        pready_o, pslverr_o;
  logic [1:0]  psel_o, penable_o, pwrite_o;
  logic [63:0] paddr_o, pwdata_o, prdata_i = '0, start_addr, end_addr;
  logic [1:0]  pready_i = '0, pslverr_i = '0;

  int vectors = 0, miscompares = 0;
  typedef struct {logic [31:0] rdata; logic err;} resp_t;
  resp_t sb[$];

  logic [1:0]  seen_sel, seen_pen, seen_wr, err_s = '0;
  logic [31:0] seen_addr[2], seen_data[2], rdata_s[2];
  int          acc_cnt[2], wait_s[2];
  logic        hang = 1'b0;
  int          lat;

  always #5 clk = ~clk;

  apb_node_reg #(.NB_MASTER(2), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .START_ADDR_i(start_addr), .END_ADDR_i(end_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_map(input logic [31:0] s0a, s0b, s1a, s1b);
    start_addr = {s1a, s0a};
    end_addr   = {s1b, s0b};
  endtask

  task automatic clear_seen();
    seen_sel = '0;
    seen_pen = '0;
    seen_wr  = '0;
    seen_addr = '{32'h0, 32'h0};
    seen_data = '{32'h0, 32'h0};
  endtask

  // slaves: ready after wait_s ACCESS cycles unless hung; record what they observe
  initial begin
    wait_s  = '{0, 0};
    acc_cnt = '{0, 0};
    rdata_s = '{32'h0, 32'h0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (psel_o[i]) seen_sel[i] = 1'b1;
        if (psel_o[i] && penable_o[i]) begin
          acc_cnt[i]++;
          seen_pen[i]  = 1'b1;
          seen_addr[i] = paddr_o[i*32 +: 32];
          seen_data[i] = pwdata_o[i*32 +: 32];
          seen_wr[i]   = pwrite_o[i];
        end else acc_cnt[i] = 0;
        pready_i[i]         = psel_o[i] && penable_o[i] && !hang && acc_cnt[i] > wait_s[i];
        pslverr_i[i]        = err_s[i];
        prdata_i[i*32 +: 32] = rdata_s[i];
      end
    end
  end

  initial forever begin
    resp_t e;
    @(negedge clk);
    if (pready_o) begin
      if (sb.size() == 0) chk("unexpected_pready", 32'(pready_o), 32'd0);
      else begin
        e = sb.pop_front();
        chk("prdata", prdata_o, e.rdata);
        chk("pslverr", 32'(pslverr_o), 32'(e.err));
      end
    end
  end

  task automatic xfer(input logic wr, input logic [31:0] a, d, input int limit, output int l);
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = d;
    @(posedge clk); #1;
    penable_i = 1'b1;
    l = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (pready_o) begin
        l = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (l >= 0) begin
      @(posedge clk); #1;
      psel_i = 1'b0; penable_i = 1'b0;
    end
  endtask

  task automatic run(input string name, input logic wr, input logic [31:0] a, d, rd,
                     input logic er, input int exp_lat);
    int l;
    sb.push_back('{rd, er});
    clear_seen();
    xfer(wr, a, d, 50, l);
    chk({name, "_lat"}, 32'(l), 32'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_map(32'h0, 32'hFFF, 32'h1000, 32'h1FFF);
    clear_seen();
    repeat (2) @(posedge clk); #1;
    chk("rst_pready", 32'(pready_o), 32'd0);
    chk("rst_pslverr", 32'(pslverr_o), 32'd0);
    chk("rst_prdata", prdata_o, 32'd0);
    chk("rst_psel", 32'({psel_o, penable_o, pwrite_o}), 32'd0);
    chk("rst_bus", 32'(|{paddr_o, pwdata_o}), 32'd0);
    rst = 1'b0;

    rdata_s[1] = 32'hFFFF_FFFF;
    run("wr_s1", 1'b1, 32'h1004, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
    chk("wr_addr", seen_addr[1], 32'h1004);
    chk("wr_data", seen_data[1], 32'hDEAD_BEEF);
    chk("wr_sel", 32'({seen_pen, seen_sel, seen_wr}), 32'b10_10_10);

    wait_s[0] = 3; rdata_s[0] = 32'h1234_5678;
    run("rd_s0", 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 6);
    chk("rd_sel", 32'(seen_sel), 32'b01);
    chk("rd_addr", seen_addr[0], 32'h10);
    wait_s[0] = 0;

    run("miss", 1'b0, 32'h8000, 32'h0, 32'h0, 1'b1, 1);
    chk("miss_sel", 32'(seen_sel), 32'b00);

    err_s = 2'b10; rdata_s[1] = 32'hAAAA_5555;
    run("slverr", 1'b0, 32'h1FFF, 32'h0, 32'hAAAA_5555, 1'b1, 3);
    chk("slverr_sel", 32'(seen_sel), 32'b10);
    err_s = 2'b00;

    rdata_s[0] = 32'h0F0F_0F0F;
    run("edge_0fff", 1'b0, 32'hFFF, 32'h0, 32'h0F0F_0F0F, 1'b0, 3);
    chk("edge_0fff_sel", 32'(seen_sel), 32'b01);
    run("edge_2000", 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 1);

    set_map(32'h0, 32'hFFFF, 32'h1000, 32'h1FFF);
    rdata_s[0] = 32'h0BAD_F00D;
    run("overlap", 1'b0, 32'h1000, 32'h0, 32'h0BAD_F00D, 1'b0, 3);
    chk("overlap_sel", 32'(seen_sel), 32'b01);
    set_map(32'h0, 32'hFFF, 32'h1000, 32'h1FFF);

    clear_seen();
    wait_s[0] = 2;
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h20;
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (10) @(posedge clk);
    chk("abort_downstream", 32'(seen_pen), 32'b01);
    wait_s[0] = 0;

    rdata_s[1] = 32'h3141_5926;
    run("post_abort", 1'b0, 32'h1000, 32'h0, 32'h3141_5926, 1'b0, 3);

    hang = 1'b1; rdata_s[0] = 32'h7777_7777;
`ifdef APB_NODE_TIMEOUT_EN
    run("timeout", 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 6);
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h40;
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(posedge clk); #1;
`else
    xfer(1'b0, 32'h40, 32'h0, 1000, lat);
    chk("no_timeout_lat", 32'(lat), 32'(-1));
`endif
    #2;
    chk("pre_rst_psel", 32'({psel_o, penable_o}), 32'b01_01);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'({psel_o, penable_o, pwrite_o, pready_o, pslverr_o}), 32'd0);
    chk("mid_rst_bus", 32'(|{paddr_o, pwdata_o, prdata_o}), 32'd0);
    psel_i = 1'b0; penable_i = 1'b0; hang = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    rdata_s[1] = 32'h55AA_55AA;
    run("post_rst", 1'b0, 32'h1008, 32'h0, 32'h55AA_55AA, 1'b0, 3);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/apb_node_reg.md
APB_NODE_REG -- requirements
Module: apb_node_reg

Interface
REQ-001 The block SHALL have parameter NB_MASTER, default 8, meaning number of downstream APB slaves (1..32).
REQ-002 The block SHALL have parameter APB_ADDR_WIDTH, default 32, meaning address width on all ports.
REQ-003 The block SHALL have parameter APB_DATA_WIDTH, default 32, meaning read/write data width on all ports.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 256, meaning maximum ACCESS-phase wait cycles (>=2).
REQ-005 The block SHALL have these ports:
- clk_i  in  1  clock; one clock only.
- rst_i  in  1  asynchronous, active-high reset.
- psel_i, penable_i, pwrite_i  in  1  upstream APB control.
- paddr_i  in  APB_ADDR_WIDTH  upstream address.
- pwdata_i  in  APB_DATA_WIDTH  upstream write data.
- prdata_o  out  APB_DATA_WIDTH  upstream read data.
- pready_o, pslverr_o  out  1  upstream response.
- psel_o, penable_o, pwrite_o  out  NB_MASTER  per-slave control.
- paddr_o  out  NB_MASTER x APB_ADDR_WIDTH  per-slave address.
- pwdata_o  out  NB_MASTER x APB_DATA_WIDTH  per-slave write data.
- prdata_i  in  NB_MASTER x APB_DATA_WIDTH  per-slave read data.
- pready_i, pslverr_i  in  NB_MASTER  per-slave response.
- START_ADDR_i, END_ADDR_i  in  NB_MASTER x APB_ADDR_WIDTH  inclusive region bounds.

Function
REQ-006 Decode SHALL flag slave i as a hit when START_ADDR_i[i] <= paddr <= END_ADDR_i[i] (unsigned); on overlapping hits the lowest index SHALL win.
REQ-007 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP.
REQ-008 In IDLE, when psel_i=1 and penable_i=0, the block SHALL latch paddr_i, pwdata_i, pwrite_i and the decode result; next state SHALL be SETUP on a hit, or RESP with pslverr_o=1 and prdata_o=0 on a miss.
REQ-009 In SETUP, the block SHALL drive psel_o[idx]=1 and penable_o[idx]=0 for one cycle, then go to ACCESS.
REQ-010 In ACCESS, the block SHALL drive psel_o[idx]=1 and penable_o[idx]=1; when pready_i[idx]=1, it SHALL register prdata_i[idx] and pslverr_i[idx] and go to RESP.
REQ-011 In RESP, the block SHALL drive pready_o=1 for exactly one cycle with the registered prdata_o/pslverr_o, then go to IDLE; pready_o SHALL be 0 in every other state.
REQ-012 Hit latency SHALL be: setup-phase cycle N, pready_o high at N+3+W, where W is the number of slave wait cycles.
REQ-013 Non-selected slaves SHALL see psel/penable/pwrite/paddr/pwdata all 0; the selected slave SHALL see the latched values, stable from SETUP through ACCESS.
REQ-014 prdata_o SHALL be 0 on writes, on decode miss and on timeout.
REQ-015 If psel_i drops before RESP, the downstream transfer SHALL still complete, no pready_o SHALL be issued, and the FSM SHALL return to IDLE.
REQ-016 Upstream inputs SHALL be ignored outside IDLE, apart from the abort check in REQ-015.

Reset
REQ-017 While rst_i=1, the FSM SHALL be in IDLE, all outputs SHALL be 0, and all latched registers and the timeout counter SHALL be 0; asserting rst_i mid-transfer SHALL drop psel_o immediately without any upstream response.

Configuration
REQ-018 Macro APB_NODE_TIMEOUT_EN SHALL compile the access timeout in or out.
- Defined: a counter SHALL clear on SETUP entry and increment each ACCESS cycle without pready_i[idx]. When it reaches TIMEOUT_CYCLES-1, the block SHALL deassert psel_o/penable_o and go to RESP with pslverr_o=1 and prdata_o=0. If pready_i arrives in the same cycle, the slave response SHALL win.
- Undefined: no counter SHALL exist, and ACCESS SHALL wait indefinitely.

Structure
REQ-019 Package apb_node_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS/RESP) and the default TIMEOUT_CYCLES constant.
REQ-020 Decode SHALL be a combinational sub-module apb_addr_decode producing a hit flag and a $clog2(NB_MASTER)-bit index.

Verification
REQ-021 Regions 0x0000-0x0FFF (s0) and 0x1000-0x1FFF (s1): write 0xDEADBEEF to 0x1004, s1 pready=1 at once -> s1 sees psel/penable with addr 0x1004 and data 0xDEADBEEF, pready_o high at N+3, pslverr_o=0.
REQ-022 Read 0x0010, s0 returns 0x12345678 after 3 wait cycles -> pready_o high at N+6, prdata_o=0x12345678, psel_o[1] never high.
REQ-023 Read 0x8000 (unmapped) -> no psel_o, pready_o=1 and pslverr_o=1 at N+1, prdata_o=0.
REQ-024 Overlap s0=0x0-0xFFFF, s1=0x1000-0x1FFF; access 0x1000 -> only psel_o[0] asserted.
REQ-025 With APB_NODE_TIMEOUT_EN and TIMEOUT_CYCLES=4, s0 never ready -> psel_o[0] drops after 4 ACCESS cycles, pslverr_o=1; an identical run without the macro sees no response after 1000 cycles.
REQ-026 Assert rst_i during ACCESS -> all outputs 0 in the same cycle; the next transfer after release completes normally.
